// File: rtl/fifo_write_frontend_pkg.sv
// Shared types and helpers for the FIFO write-domain front end.
package fifo_write_frontend_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Zero-extended Gray codes decode to zero-extended binary, so callers of any width up to GRAY_MAX_W slice the low bits.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_write_frontend_if.sv
// Producer valid/ready stream into the FIFO write front end.
interface fifo_write_frontend_if #(
  parameter int unsigned data_Width = 8
);

  logic                  s_Valid;
  logic [data_Width-1:0] s_Data;
  logic                  s_Ready;

  modport master (
    output s_Valid,
    output s_Data,
    input  s_Ready
  );

  modport slave (
    input  s_Valid,
    input  s_Data,
    output s_Ready
  );

endinterface

// File: rtl/fifo_write_frontend_skid.sv
// Two-entry valid/ready skid buffer; main always holds the oldest beat.
module fifo_skid_buffer
  import fifo_write_frontend_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_pop_i
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              accept_s;
  logic              pop_s;

  assign accept_s    = in_valid_i & ready_q;
  assign pop_s       = out_pop_i & (state_q != EMPTY);
  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

  // Occupancy and data-steering next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          state_d = ONE;
          main_d  = in_data_i;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          state_d = ONE;
          main_d  = in_data_i;
        end else if (accept_s) begin
          state_d = TWO;
          skid_d  = in_data_i;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (pop_s) begin
          state_d = ONE;
          main_d  = skid_q;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    ready_d = (state_d != TWO);
  end

  // State, payload and ready registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= {DATA_W{1'b0}};
      skid_q  <= {DATA_W{1'b0}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/fifo_write_frontend.sv
// Write-domain front end: skid-buffered producer stream, full-gated write strobe,
// and registered fill level / almost-full derived from the Gray pointers.
module fifo_write_frontend
  import fifo_write_frontend_pkg::*;
#(
  parameter int unsigned address_Size   = 3,
  parameter int unsigned data_Width     = 8,
  parameter int unsigned almost_Full_Th = 6
) (
  input  logic                    w_Clk,
  input  logic                    w_Rst,
  fifo_write_frontend_if.slave    s_if,
  output logic                    w_Inc,
  output logic [data_Width-1:0]   w_Data,
  input  logic                    fifo_Full,
  input  logic [address_Size:0]   w_Ptr,
  input  logic [address_Size:0]   wsync_Rptr,
  output logic [address_Size:0]   w_Level,
  output logic                    almost_Full
);

  localparam int unsigned PTR_W = address_Size + 1;
  localparam logic [PTR_W-1:0] ALMOST_TH = PTR_W'(almost_Full_Th);

  logic                  main_valid_s;
  logic [GRAY_MAX_W-1:0] wbin_full_s;
  logic [GRAY_MAX_W-1:0] rbin_full_s;
  logic [PTR_W-1:0]      level_s;
  logic                  almost_s;
  logic                  unused_hi_s;
  logic [PTR_W-1:0]      level_q;
  logic                  almost_q;

  fifo_skid_buffer #(
    .DATA_W (data_Width)
  ) u_skid (
    .clk_i       (w_Clk),
    .rst_i       (w_Rst),
    .in_valid_i  (s_if.s_Valid),
    .in_data_i   (s_if.s_Data),
    .in_ready_o  (s_if.s_Ready),
    .out_valid_o (main_valid_s),
    .out_data_o  (w_Data),
    .out_pop_i   (w_Inc)
  );

  // The strobe doubles as the pop, so a full FIFO simply stalls the head beat.
  assign w_Inc = main_valid_s & ~fifo_Full;

  assign wbin_full_s = gray2bin(GRAY_MAX_W'(w_Ptr));
  assign rbin_full_s = gray2bin(GRAY_MAX_W'(wsync_Rptr));
  assign unused_hi_s = ^{wbin_full_s[GRAY_MAX_W-1:PTR_W], rbin_full_s[GRAY_MAX_W-1:PTR_W]};

  // Modulo-2^PTR_W difference absorbs pointer wrap; a full FIFO reads as 2^address_Size.
  assign level_s  = wbin_full_s[PTR_W-1:0] - rbin_full_s[PTR_W-1:0];
  assign almost_s = (level_s >= ALMOST_TH);

  // Level and almost-full registers.
  always_ff @(posedge w_Clk) begin
    if (w_Rst) begin
      level_q  <= {PTR_W{1'b0}};
      almost_q <= 1'b0;
    end else begin
      level_q  <= level_s;
      almost_q <= almost_s;
    end
  end

  assign w_Level     = level_q;
  assign almost_Full = almost_q;

endmodule

// File: tb/tb_fifo_write_frontend.sv
// Directed self-checking bench for fifo_write_frontend at default parameters.
module tb_fifo_write_frontend;

  logic       w_Clk;
  logic       w_Rst;
  logic       w_Inc;
  logic [7:0] w_Data;
  logic       fifo_Full;
  logic [3:0] w_Ptr;
  logic [3:0] wsync_Rptr;
  logic [3:0] w_Level;
  logic       almost_Full;

  int checks;
  int errors;

  fifo_write_frontend_if #(.data_Width(8)) s_if ();

  fifo_write_frontend #(
    .address_Size   (3),
    .data_Width     (8),
    .almost_Full_Th (6)
  ) dut (
    .w_Clk       (w_Clk),
    .w_Rst       (w_Rst),
    .s_if        (s_if),
    .w_Inc       (w_Inc),
    .w_Data      (w_Data),
    .fifo_Full   (fifo_Full),
    .w_Ptr       (w_Ptr),
    .wsync_Rptr  (wsync_Rptr),
    .w_Level     (w_Level),
    .almost_Full (almost_Full)
  );

  initial w_Clk = 1'b0;
  always #5 w_Clk = ~w_Clk;

  task automatic tick();
    @(posedge w_Clk);
    #1;
  endtask

  task automatic test_reset();
    w_Rst = 1'b1;
    s_if.s_Valid = 1'b1;
    s_if.s_Data = 8'h55;
    fifo_Full = 1'b0;
    w_Ptr = 4'b0000;
    wsync_Rptr = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_if.s_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", s_if.s_Ready); end
      checks++;
      if (w_Inc !== 1'b0) begin errors++; $display("FAIL reset_winc: got %b expected 0", w_Inc); end
      checks++;
      if (w_Level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", w_Level); end
      checks++;
      if (almost_Full !== 1'b0) begin errors++; $display("FAIL reset_almost: got %b expected 0", almost_Full); end
      checks++;
      if (w_Data !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", w_Data); end
    end
    w_Rst = 1'b0;
    s_if.s_Valid = 1'b0;
    tick();
    checks++;
    if (s_if.s_Ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", s_if.s_Ready); end
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL reset_nothing_written: got %b expected 0", w_Inc); end
  endtask

  task automatic test_streaming();
    logic [7:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      exp_d = 8'(i + 1);
      s_if.s_Valid = 1'b1;
      s_if.s_Data = exp_d;
      tick();
      checks++;
      if (s_if.s_Ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, s_if.s_Ready); end
      checks++;
      if (w_Inc !== 1'b1) begin errors++; $display("FAIL stream_winc[%0d]: got %b expected 1", i, w_Inc); end
      checks++;
      if (w_Data !== exp_d) begin errors++; $display("FAIL stream_wdata[%0d]: got %h expected %h", i, w_Data, exp_d); end
    end
    s_if.s_Valid = 1'b0;
    tick();
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", w_Inc); end
  endtask

  task automatic test_backpressure();
    fifo_Full = 1'b1;
    s_if.s_Valid = 1'b1;
    s_if.s_Data = 8'hA0;
    tick();
    checks++;
    if (s_if.s_Ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", s_if.s_Ready); end
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL bp_winc_full: got %b expected 0", w_Inc); end
    checks++;
    if (w_Data !== 8'hA0) begin errors++; $display("FAIL bp_head: got %h expected a0", w_Data); end
    s_if.s_Data = 8'hA1;
    tick();
    checks++;
    if (s_if.s_Ready !== 1'b0) begin errors++; $display("FAIL bp_ready_two: got %b expected 0", s_if.s_Ready); end
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL bp_winc_two: got %b expected 0", w_Inc); end
    s_if.s_Data = 8'hA2;
    tick();
    checks++;
    if (s_if.s_Ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b expected 0", s_if.s_Ready); end
    fifo_Full = 1'b0;
    #1;
    checks++;
    if (w_Inc !== 1'b1 || w_Data !== 8'hA0) begin errors++; $display("FAIL bp_out0: got inc=%b data=%h expected inc=1 data=a0", w_Inc, w_Data); end
    tick();
    checks++;
    if (w_Inc !== 1'b1 || w_Data !== 8'hA1) begin errors++; $display("FAIL bp_out1: got inc=%b data=%h expected inc=1 data=a1", w_Inc, w_Data); end
    checks++;
    if (s_if.s_Ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", s_if.s_Ready); end
    tick();
    checks++;
    if (w_Inc !== 1'b1 || w_Data !== 8'hA2) begin errors++; $display("FAIL bp_out2: got inc=%b data=%h expected inc=1 data=a2", w_Inc, w_Data); end
    s_if.s_Valid = 1'b0;
    tick();
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", w_Inc); end
  endtask

  task automatic test_level();
    w_Ptr = 4'b0101;
    wsync_Rptr = 4'b0000;
    #1;
    checks++;
    if (w_Level !== 4'd0) begin errors++; $display("FAIL level_lag: got %0d expected 0", w_Level); end
    tick();
    checks++;
    if (w_Level !== 4'd6) begin errors++; $display("FAIL level_6: got %0d expected 6", w_Level); end
    checks++;
    if (almost_Full !== 1'b1) begin errors++; $display("FAIL almost_at_th: got %b expected 1", almost_Full); end
    wsync_Rptr = 4'b0011;
    tick();
    checks++;
    if (w_Level !== 4'd4) begin errors++; $display("FAIL level_4: got %0d expected 4", w_Level); end
    checks++;
    if (almost_Full !== 1'b0) begin errors++; $display("FAIL almost_below: got %b expected 0", almost_Full); end
    w_Ptr = 4'b0111;
    wsync_Rptr = 4'b0000;
    tick();
    checks++;
    if (w_Level !== 4'd5 || almost_Full !== 1'b0) begin errors++; $display("FAIL level_5: got lvl=%0d af=%b expected lvl=5 af=0", w_Level, almost_Full); end
  endtask

  task automatic test_wrap();
    w_Ptr = 4'b0001;
    wsync_Rptr = 4'b1011;
    tick();
    checks++;
    if (w_Level !== 4'd4) begin errors++; $display("FAIL wrap_level_4: got %0d expected 4", w_Level); end
    w_Ptr = 4'b1100;
    wsync_Rptr = 4'b0000;
    tick();
    checks++;
    if (w_Level !== 4'd8) begin errors++; $display("FAIL wrap_full_8: got %0d expected 8", w_Level); end
    checks++;
    if (almost_Full !== 1'b1) begin errors++; $display("FAIL wrap_almost: got %b expected 1", almost_Full); end
  endtask

  task automatic test_mid_reset();
    w_Ptr = 4'b0101;
    wsync_Rptr = 4'b0000;
    fifo_Full = 1'b1;
    s_if.s_Valid = 1'b1;
    s_if.s_Data = 8'h11;
    tick();
    s_if.s_Data = 8'h22;
    tick();
    s_if.s_Valid = 1'b0;
    checks++;
    if (s_if.s_Ready !== 1'b0) begin errors++; $display("FAIL mid_two_ready: got %b expected 0", s_if.s_Ready); end
    w_Rst = 1'b1;
    tick();
    checks++;
    if (s_if.s_Ready !== 1'b0 || w_Data !== 8'h00) begin errors++; $display("FAIL mid_rst_state: got rdy=%b data=%h expected rdy=0 data=00", s_if.s_Ready, w_Data); end
    checks++;
    if (w_Level !== 4'd0 || almost_Full !== 1'b0) begin errors++; $display("FAIL mid_rst_level: got lvl=%0d af=%b expected lvl=0 af=0", w_Level, almost_Full); end
    w_Rst = 1'b0;
    fifo_Full = 1'b0;
    #1;
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL mid_no_winc0: got %b expected 0", w_Inc); end
    tick();
    checks++;
    if (s_if.s_Ready !== 1'b1) begin errors++; $display("FAIL mid_ready_back: got %b expected 1", s_if.s_Ready); end
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL mid_no_winc1: got %b expected 0", w_Inc); end
    tick();
    checks++;
    if (w_Inc !== 1'b0) begin errors++; $display("FAIL mid_no_winc2: got %b expected 0", w_Inc); end
    w_Ptr = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w_Rst = 1'b1;
    s_if.s_Valid = 1'b0;
    s_if.s_Data = 8'h00;
    fifo_Full = 1'b0;
    w_Ptr = 4'b0000;
    wsync_Rptr = 4'b0000;
    test_reset();
    test_streaming();
    test_backpressure();
    test_level();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
